div32_arbiter: RTL and testbench

- Shares one combinational 32-bit-quotient divider (K-bit divisor, (K+32)-bit dividend) between NREQ requesters.
- Round-robin arbitration, valid/ready request and response handshakes.
- Operands are registered before the divider and the result is registered after it, with a programmable multicycle wait so the deep divider path can be multicycle-constrained.
- Sits between integer/fixed-point units and the single shared divider instance; the divider is instantiated inside this block.

---
 rtl/div32_arbiter.sv | 148 ++++++++++++++
 tb/tb_div32_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div32_arbiter.sv
// Round-robin arbiter sharing one combinational (K+32)/K divider between NREQ requesters.
// Latency: accept edge E0 -> resp_valid after edge E0+CALC_CYCLES; one op in flight at a time.
// Backpressure: req_ready only in IDLE; the result is held in RESP until the owner's resp_ready.
module div32_arbiter #(
  parameter int K           = 32,
  parameter int NREQ        = 2,
  parameter int CALC_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*(K+32)-1:0] req_x,
  input  logic [NREQ*K-1:0]      req_d,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [31:0]            resp_q,
  output logic [K-1:0]           resp_r,
  output logic                   resp_dbz,
  output logic                   resp_ovf
);

  localparam int XW = K + 32;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   grant;
  logic            grant_vld;
  logic [IW:0]     scan_idx;
  logic [CW-1:0]   cnt;
  logic [XW-1:0]   op_x;
  logic [K-1:0]    op_d;

  logic [XW-1:0]   x_arr [NREQ];
  logic [K-1:0]    d_arr [NREQ];

  logic [K-1:0]    div_dsafe;
  logic [31:0]     div_q;
  logic [K-1:0]    div_r;
  logic            div_dbz;
  logic            div_ovf;

  // Unpack the flat operand buses into per-requester views.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x[gi*XW +: XW];
    assign d_arr[gi] = req_d[gi*K +: K];
  end

  // Shared divider, fed only from the operand registers so its path can be multicycled.
  // A zero divisor is replaced by 1 to keep the divider output defined; dbz overrides it.
  assign div_dbz   = (op_d == '0);
  assign div_dsafe = div_dbz ? K'(1) : op_d;
  assign div_q     = 32'(op_x / XW'(div_dsafe));
  assign div_r     = K'(op_x % XW'(div_dsafe));
  assign div_ovf   = !div_dbz && (op_x[XW-1:32] >= op_d);

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan_idx  = '0;
    for (int j = 0; j < NREQ; j++) begin
      scan_idx = {1'b0, rr_ptr} + (IW+1)'(j);
      if (scan_idx >= (IW+1)'(NREQ)) scan_idx = scan_idx - (IW+1)'(NREQ);
      if (!grant_vld && req_valid[scan_idx[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = scan_idx[IW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = CALC;
          if (!rst) req_ready[grant] = 1'b1;
        end
      end
      CALC: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, wait counter, result capture and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      cnt      <= '0;
      op_x     <= '0;
      op_d     <= '0;
      resp_q   <= '0;
      resp_r   <= '0;
      resp_dbz <= 1'b0;
      resp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_x  <= x_arr[grant];
            op_d  <= d_arr[grant];
            owner <= grant;
            cnt   <= CW'(CALC_CYCLES - 1);
          end
        end
        CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_dbz <= div_dbz;
            resp_ovf <= div_ovf;
            resp_q   <= div_dbz ? '1 : div_q;
            resp_r   <= div_dbz ? op_x[K-1:0] : div_r;
          end
        end
        RESP: begin
          if (resp_ready[owner]) begin
            rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_arbiter.sv
// Self-checking bench for div32_arbiter (K=32, NREQ=2, CALC_CYCLES=2).
// Expected results are queued at accept and compared at the response handshake.
// Covers round-robin order, arithmetic corners, backpressure and mid-op reset.
module tb_div32_arbiter;

  localparam int K    = 32;
  localparam int NREQ = 2;
  localparam int CC   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*(K+32)-1:0] req_x;
  logic [NREQ*K-1:0]      req_d;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [31:0]            resp_q;
  logic [K-1:0]           resp_r;
  logic                   resp_dbz;
  logic                   resp_ovf;

  div32_arbiter #(.K(K), .NREQ(NREQ), .CALC_CYCLES(CC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_d(req_d),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_q(resp_q), .resp_r(resp_r),
    .resp_dbz(resp_dbz), .resp_ovf(resp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    logic        chk_qr;
  } exp_t;

  typedef struct {
    int          id;
    logic [63:0] x;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    logic        chk_qr;
  } vec_t;

  exp_t            sb [$];
  exp_t            mon_e;
  exp_t            rr_e [NREQ];
  vec_t            vt [11];
  int              errors   = 0;
  int              checks   = 0;
  int              cyc      = 0;
  int              acc_edge = 0;
  logic [NREQ-1:0] rv_prev  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int owner, input logic [31:0] q, input logic [31:0] r,
                              input logic dbz, input logic ovf, input logic chk_qr);
    exp_t e;
    e.owner = owner; e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.chk_qr = chk_qr;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor and handshake invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      rv_prev = '0;
    end else begin
      chk("resp_valid_onehot", 64'($countones(resp_valid) <= 1), 1);
      chk("req_ready_onehot", 64'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)), 1);
      if (resp_valid != '0 && rv_prev == '0)
        chk("latency", 64'(cyc - acc_edge), CC);
      if ((resp_valid & resp_ready) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_owner", 64'(resp_valid), 64'(1 << mon_e.owner));
          chk("resp_dbz", 64'(resp_dbz), 64'(mon_e.dbz));
          chk("resp_ovf", 64'(resp_ovf), 64'(mon_e.ovf));
          if (mon_e.chk_qr) begin
            chk("resp_q", 64'(resp_q), 64'(mon_e.q));
            chk("resp_r", 64'(resp_r), 64'(mon_e.r));
          end
        end
      end
      rv_prev = resp_valid;
    end
  end

  task automatic set_req(input int id, input logic [63:0] x, input logic [31:0] d);
    req_x[id*64 +: 64] = x;
    req_d[id*32 +: 32] = d;
    req_valid[id]      = 1'b1;
  endtask

  task automatic wait_accept(input int id, input exp_t e);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id] && req_valid[id]) begin
        got      = 1'b1;
        acc_edge = cyc + 1;
        sb.push_back(e);
      end
    end
    chk($sformatf("accept_req%0d", id), 64'(got), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_any_accept(output int g);
    bit got;
    got = 1'b0;
    g   = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != '0) begin
        got      = 1'b1;
        g        = req_ready[1] ? 1 : 0;
        acc_edge = cyc + 1;
        sb.push_back(rr_e[g]);
      end
    end
    chk("accept_any", 64'(got), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(posedge clk);
    chk("drain", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    set_req(v.id, v.x, v.d);
    wait_accept(v.id, mk(v.id, v.q, v.r, v.dbz, v.ovf, v.chk_qr));
    req_valid = '0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   g;
    logic seen;

    //        id  x                         d              q              r              dbz   ovf   chk
    vt[0]  = '{0, 64'd100,                  32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 1'b1};
    vt[1]  = '{1, 64'h1234,                 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{0, 64'h0000_0005_0000_0000,  32'd5,         32'd0,         32'd0,         1'b0, 1'b1, 1'b0};
    vt[3]  = '{0, 64'h0000_0004_FFFF_FFFF,  32'd5,         32'hFFFF_FFFF, 32'd4,         1'b0, 1'b0, 1'b1};
    vt[4]  = '{1, 64'd1000,                 32'd3,         32'd333,       32'd1,         1'b0, 1'b0, 1'b1};
    vt[5]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0, 1'b1, 1'b0};
    vt[6]  = '{0, 64'd0,                    32'd1,         32'd0,         32'd0,         1'b0, 1'b0, 1'b1};
    vt[7]  = '{1, 64'h0000_0001_0000_0000,  32'd2,         32'h8000_0000, 32'd0,         1'b0, 1'b0, 1'b1};
    vt[8]  = '{0, 64'h0000_0000_FFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 32'hF,         1'b0, 1'b0, 1'b1};
    vt[9]  = '{1, 64'h0000_FFFF_0000_1234,  32'h1_0000,    32'hFFFF_0000, 32'h1234,      1'b0, 1'b0, 1'b1};
    vt[10] = '{0, 64'hABCD_0000_0000_0042,  32'd0,         32'hFFFF_FFFF, 32'h42,        1'b1, 1'b0, 1'b1};

    rr_e[0] = mk(0, 32'd100, 32'd0, 1'b0, 1'b0, 1'b1);
    rr_e[1] = mk(1, 32'd333, 32'd1, 1'b0, 1'b0, 1'b1);

    // Reset state, with both requesters already asking.
    rst        = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    req_d      = '0;
    resp_ready = 2'b11;
    set_req(0, 64'd1000, 32'd10);
    set_req(1, 64'd1000, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_q", 64'(resp_q), 0);
    chk("rst_resp_r", 64'(resp_r), 0);
    chk("rst_resp_dbz", 64'(resp_dbz), 0);
    chk("rst_resp_ovf", 64'(resp_ovf), 0);
    rst = 1'b0;

    // Round-robin with both requesters held valid: grants 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      wait_any_accept(g);
      chk($sformatf("rr_grant%0d", k), 64'(g), 64'(k % 2));
    end
    req_valid = '0;
    drain();

    // Table of single-requester operations, including dbz and ovf corners.
    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Backpressure: owner 0 stalls its response while requester 1 waits.
    // The non-owner resp_ready bit is held high and must be ignored.
    resp_ready = 2'b10;
    set_req(0, 64'd1000, 32'd10);
    wait_accept(0, rr_e[0]);
    req_valid[0] = 1'b0;
    set_req(1, 64'd1000, 32'd3);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = resp_valid[0];
    end
    chk("bp_resp_seen", 64'(seen), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'(2'b01));
      chk("bp_resp_q", 64'(resp_q), 100);
      chk("bp_resp_r", 64'(resp_r), 0);
      chk("bp_req_ready", 64'(req_ready), 0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    @(posedge clk); #1;
    chk("bp_next_ready", 64'(req_ready), 64'(2'b10));
    chk("bp_resp_dropped", 64'(resp_valid), 0);
    wait_accept(1, rr_e[1]);
    req_valid = '0;
    drain();

    // Mid-CALC reset: leave rr_ptr at 1 first so its reset to 0 is visible.
    run_vec(vt[0]);
    set_req(1, 64'd1000, 32'd3);
    wait_accept(1, rr_e[1]);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("mrst_req_ready", 64'(req_ready), 0);
    chk("mrst_resp_valid", 64'(resp_valid), 0);
    chk("mrst_resp_q", 64'(resp_q), 0);
    chk("mrst_resp_r", 64'(resp_r), 0);
    chk("mrst_resp_dbz", 64'(resp_dbz), 0);
    chk("mrst_resp_ovf", 64'(resp_ovf), 0);
    sb.delete();
    set_req(0, 64'd1000, 32'd10);
    set_req(1, 64'd1000, 32'd3);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mrst_hold_valid", 64'(resp_valid), 0);
      chk("mrst_hold_ready", 64'(req_ready), 0);
    end
    rst = 1'b0;
    wait_any_accept(g);
    chk("mrst_first_grant", 64'(g), 0);
    req_valid = '0;
    drain();
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
